// File: rtl/morph_window_filter_pkg.sv
// Shared definitions for the streaming morphology filter.
// - state_e      : control FSM states (idle, accepting pixels, draining outputs)
// - ModeErode    : mode value selecting AND over the mask
// - ModeDilate   : mode value selecting OR over the mask
package morph_window_filter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic ModeErode  = 1'b0;
  localparam logic ModeDilate = 1'b1;

endpackage

// File: rtl/morph_line_window.sv
// K-1 line buffers plus a KxK register window for raster-order streams.
// Ports:
// - clock       : rising-edge clock
// - shift       : advance the window by one column and update the line buffer at addr
// - addr        : column of the pixel being shifted in
// - pixel       : newest pixel (N planes)
// - window_next : window as it is after this shift; position (r,c) at [(r*K+c)*N +: N],
//                 r=0 oldest row, c=K-1 newest column
// Storage is never cleared; stale contents are masked by the padding logic in the top.
module morph_line_window #(
  parameter int unsigned N         = 1,
  parameter int unsigned K         = 3,
  parameter int unsigned MAX_WIDTH = 640,
  parameter int unsigned AW        = 10
) (
  input  logic             clock,
  input  logic             shift,
  input  logic [AW-1:0]    addr,
  input  logic [N-1:0]     pixel,
  output logic [K*K*N-1:0] window_next
);

  localparam int unsigned LW = (K - 1) * N;

  // One entry per column holds that column's previous K-1 rows, row 0 oldest.
  logic [LW-1:0]    line_mem [MAX_WIDTH];
  logic [LW-1:0]    line_rd;
  logic [LW-1:0]    line_wr;
  logic [K*N-1:0]   column;
  logic [K*K*N-1:0] win_q;

  assign line_rd = line_mem[addr];
  assign column  = {pixel, line_rd};
  // Drop the oldest row, append the new pixel as the youngest.
  assign line_wr = column[K*N-1:N];

  always_ff @(posedge clock) begin
    if (shift) begin
      line_mem[addr] <= line_wr;
    end
  end

  always_comb begin
    window_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (c == K - 1) begin
          window_next[(r*K+c)*N +: N] = column[r*N +: N];
        end else begin
          window_next[(r*K+c)*N +: N] = win_q[(r*K+c+1)*N +: N];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (shift) begin
      win_q <= window_next;
    end
  end

endmodule

// File: rtl/morph_window_filter.sv
// Streaming erosion/dilation over an odd KxK mask, N independent bit planes, raster order.
// One output pixel per input pixel; out-of-frame and masked-off taps read the identity
// of the operation (1 for erosion, 0 for dilation).
// Ports:
// - clock, reset        : rising-edge clock, synchronous active-high reset
// - width, height, mode : frame geometry and operation, latched on the first pixel of a frame
// - in_write/in_ready   : input handshake, transfer = in_write & in_ready
// - in_pixel            : input pixel
// - out_read/out_pixel  : single-cycle output strobe and filtered pixel
// - busy                : frame in progress
module morph_window_filter
  import morph_window_filter_pkg::*;
#(
  parameter int unsigned    N         = 1,
  parameter int unsigned    K         = 3,
  parameter int unsigned    MAX_WIDTH = 640,
  parameter logic [K*K-1:0] MASK      = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [15:0]  width,
  input  logic [15:0]  height,
  input  logic         mode,
  input  logic         in_write,
  output logic         in_ready,
  input  logic [N-1:0] in_pixel,
  output logic         out_read,
  output logic [N-1:0] out_pixel,
  output logic         busy
);

  localparam int unsigned D     = (K - 1) / 2;
  localparam int unsigned AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned LeadW = 20;

  state_e           state_q, state_d;
  logic [15:0]      w_q, w_d, h_q, h_d;
  logic             mode_q, mode_d;
  logic [15:0]      in_col_q, in_col_d, in_row_q, in_row_d;
  logic [15:0]      out_col_q, out_col_d, out_row_q, out_row_d;
  logic [LeadW-1:0] lead_q, lead_d, lead_cur;
  logic             out_read_q;
  logic [N-1:0]     out_pixel_q;

  logic             idle, xfer, shift, emit;
  logic [15:0]      cur_w, cur_h, col_cur, row_cur;
  logic             in_wrap, in_last, out_wrap, out_last;
  logic [K*K*N-1:0] window_next;
  logic [N-1:0]     result;

  assign idle     = (state_q == StIdle);
  assign in_ready = (state_q != StFlush);
  assign busy     = !idle;
  assign xfer     = in_write & in_ready;
  // The window keeps shifting during flush so the remaining centres reach it.
  assign shift    = xfer | (state_q == StFlush);

  // Geometry is taken live on the first pixel, latched afterwards.
  assign cur_w    = idle ? width  : w_q;
  assign cur_h    = idle ? height : h_q;
  assign col_cur  = idle ? 16'd0  : in_col_q;
  assign row_cur  = idle ? 16'd0  : in_row_q;

  // Shifts remaining before the window centre holds pixel 0: D full lines plus D pixels.
  assign lead_cur = idle ? (LeadW'(D) * LeadW'(width) + LeadW'(D)) : lead_q;
  assign emit     = shift & (lead_cur == '0);

  assign in_wrap  = (col_cur == cur_w - 16'd1);
  assign in_last  = in_wrap & (row_cur == cur_h - 16'd1);
  assign out_wrap = (out_col_q == w_q - 16'd1);
  assign out_last = out_wrap & (out_row_q == h_q - 16'd1);

  morph_line_window #(
    .N         (N),
    .K         (K),
    .MAX_WIDTH (MAX_WIDTH),
    .AW        (AW)
  ) u_line_window (
    .clock       (clock),
    .shift       (shift),
    .addr        (col_cur[AW-1:0]),
    .pixel       (in_pixel),
    .window_next (window_next)
  );

  // Padding and mask gating, then AND/OR reduction per plane around the output pointer.
  always_comb begin
    int   rr;
    int   cc;
    logic tap;
    result = '0;
    rr     = 0;
    cc     = 0;
    tap    = 1'b0;
    for (int n = 0; n < N; n++) begin
      result[n] = (mode_q == ModeErode);
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          rr = int'(out_row_q) + r - int'(D);
          cc = int'(out_col_q) + c - int'(D);
          if (MASK[r*K+c] && rr >= 0 && rr < int'(h_q) && cc >= 0 && cc < int'(w_q)) begin
            tap       = window_next[(r*K+c)*N+n];
            result[n] = (mode_q == ModeDilate) ? (result[n] | tap) : (result[n] & tap);
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    mode_d    = mode_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    lead_d    = lead_q;

    if (idle && xfer) begin
      w_d    = width;
      h_d    = height;
      mode_d = mode;
    end

    if (shift) begin
      in_col_d = in_wrap ? 16'd0 : col_cur + 16'd1;
      in_row_d = in_wrap ? row_cur + 16'd1 : row_cur;
      lead_d   = (lead_cur == '0) ? '0 : lead_cur - LeadW'(1);
    end

    if (idle) begin
      out_col_d = '0;
      out_row_d = '0;
    end else if (emit) begin
      out_col_d = out_wrap ? 16'd0 : out_col_q + 16'd1;
      out_row_d = out_wrap ? out_row_q + 16'd1 : out_row_q;
    end

    unique case (state_q)
      StIdle:  if (xfer) state_d = in_last ? StFlush : StRun;
      StRun:   if (xfer && in_last) state_d = StFlush;
      StFlush: if (emit && out_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      w_q         <= '0;
      h_q         <= '0;
      mode_q      <= 1'b0;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      lead_q      <= '0;
      out_read_q  <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      mode_q     <= mode_d;
      in_col_q   <= in_col_d;
      in_row_q   <= in_row_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      lead_q     <= lead_d;
      out_read_q <= emit;
      if (emit) begin
        out_pixel_q <= result;
      end
    end
  end

  assign out_read  = out_read_q;
  assign out_pixel = out_pixel_q;

endmodule
